// File: rtl/encoder4_2_checker.sv
// encoder4_2_checker
//   Clocked 4-to-2 priority encoder with a valid/ready handshake and a quiz
//   scoreboard. Each accepted line vector b is encoded into a registered
//   result (a/a_none). When the consumer takes that result, the student answer
//   test_a is scored against it. A run covers N_VEC output handshakes and then
//   parks in ST_DONE until the next start pulse.
//
//   Optional feature macro: ENC_ONEHOT_CHECK_EN
//     defined   : onehot_err flags accepted vectors with more than one bit set.
//                 Such vectors always score as a pass.
//     undefined : onehot_err = 0, and scoring is pure priority encoding.
//
// Ports
//   sys_clk, sys_rst_n   clock (rising edge), async active-low reset
//   start                pulse: begin or restart a run, clear the scoreboard
//   in_valid/in_ready    input handshake for line vector b[3:0]
//   out_valid/out_ready  output handshake for a[1:0], a_none, onehot_err
//   test_a[1:0]          student answer, sampled on the output handshake
//   check_res            result of the last scored comparison
//   pass_cnt, fail_cnt   saturating score counters (CNT_W bits)
//   done                 run complete
module encoder4_2_checker #(
    parameter int N_VEC = 16,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       a,
    output logic             a_none,
    input  logic [1:0]       test_a,
    output logic             check_res,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             done,
    output logic             onehot_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int VC_W = $clog2(N_VEC + 1);
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(N_VEC - 1);

    logic [1:0]      state;
    logic [VC_W-1:0] vec_cnt;
    logic [1:0]      enc_a;
    logic            enc_none;
    logic            in_fire;
    logic            out_fire;
    logic            answer_ok;

    // Priority encode: the highest set index wins.
    always_comb begin
        enc_a    = 2'd0;
        enc_none = 1'b0;
        if (b[3])      enc_a = 2'd3;
        else if (b[2]) enc_a = 2'd2;
        else if (b[1]) enc_a = 2'd1;
        else if (b[0]) enc_a = 2'd0;
        else           enc_none = 1'b1;
    end

    // The consumer taking the current result frees the register in the same
    // cycle, so a new vector can enter while the old one leaves.
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef ENC_ONEHOT_CHECK_EN
    logic onehot_q;
    logic enc_multi;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign enc_multi  = |(b & (b - 4'd1));
    assign onehot_err = onehot_q;
    assign answer_ok  = (test_a == a) || (a_none && test_a == 2'd0) || onehot_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            onehot_q <= 1'b0;
        else if (start)
            onehot_q <= 1'b0;
        else if (state == ST_RUN && in_fire && !(out_fire && vec_cnt == VC_LAST))
            onehot_q <= enc_multi;
    end
`else
    assign onehot_err = 1'b0;
    assign answer_ok  = (test_a == a) || (a_none && test_a == 2'd0);
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            a         <= 2'b00;
            a_none    <= 1'b0;
            check_res <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            done      <= 1'b0;
            vec_cnt   <= '0;
        end else if (start) begin
            // Start wins over everything, including restart from inside a run:
            // any pending result is dropped without being scored.
            state     <= ST_RUN;
            out_valid <= 1'b0;
            check_res <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            done      <= 1'b0;
            vec_cnt   <= '0;
        end else if (state == ST_RUN) begin
            if (out_fire) begin
                check_res <= answer_ok;
                if (answer_ok) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                end
                vec_cnt <= vec_cnt + 1'b1;
            end

            if (out_fire && vec_cnt == VC_LAST) begin
                // Last result of the run: a simultaneous input is dropped.
                state     <= ST_DONE;
                done      <= 1'b1;
                out_valid <= 1'b0;
            end else if (in_fire) begin
                a         <= enc_a;
                a_none    <= enc_none;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/encoder4_2_checker.md
Name: encoder4_2_checker

Overview:
- Clocked 4-to-2 priority encoder: the inverse of the 2-4 line decoder quiz block.
- Has a valid/ready handshake and a built-in quiz scoreboard.
- Each accepted 4-bit line vector is encoded into a registered output, and a student answer (test_a) is scored against it.
- Sits between the stimulus generator and the tester display logic; the display logic reads the counters and done flag.

Parameters:
- N_VEC, 16: number of output handshakes per run before ST_DONE.
- CNT_W, 8: width of the pass/fail counters; counters saturate at 2^CNT_W-1.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a run and clears the counters.
- in_valid  input  1  line vector b is valid.
- in_ready  output  1  block can accept b this cycle.
- b  input  4  line inputs; highest set index has priority.
- out_valid  output  1  a/a_none hold an encoded result.
- out_ready  input  1  consumer accepts the result.
- a  output  2  encoded index of the highest set bit of b.
- a_none  output  1  accepted b was 4'b0000.
- test_a  input  2  student encoder answer, sampled on output handshake.
- check_res  output  1  result of the last scored comparison.
- pass_cnt  output  CNT_W  number of matching answers.
- fail_cnt  output  CNT_W  number of mismatching answers.
- done  output  1  run complete.
- onehot_err  output  1  accepted b had more than one bit set (optional feature only).

Behaviour:
- Reset (sys_rst_n=0, async): state=ST_IDLE, out_valid=0, a=2'b00, a_none=0, check_res=0, pass_cnt=0, fail_cnt=0, done=0, onehot_err=0, internal vector count=0.
- Encoding: b[3]→3, else b[2]→2, else b[1]→1, else b[0]→0. b=0 gives a=0 and a_none=1.
- FSM states:
  - ST_IDLE: in_ready=0, out_valid=0. start moves to ST_RUN next cycle.
  - ST_RUN: handshakes active.
  - ST_DONE: in_ready=0, done=1. Counters are held. start returns to ST_RUN.
- Entering ST_RUN via start: pass_cnt, fail_cnt, vector count and check_res clear on the same edge; done clears.
- Input handshake: fires when in_valid && in_ready. in_ready = (state==ST_RUN) && (!out_valid || out_ready), a combinational pass-through of out_ready.
- Output register:
  - On input fire, a/a_none load and out_valid=1 on the next edge: latency 1 cycle.
  - a/a_none/out_valid stay stable while out_valid && !out_ready.
- Simultaneous output fire and input fire: new result loads, out_valid stays 1, so full throughput of 1/cycle is sustained.
- Output fire without input fire: out_valid→0.
- Scoring, on output fire:
  - If test_a==a, or a_none=1 and test_a==0: check_res←1 and pass_cnt++.
  - Otherwise: check_res←0 and fail_cnt++.
  - Counters saturate; they never wrap.
  - Vector count increments.
- Completion:
  - When the output fire brings vector count to N_VEC, the state becomes ST_DONE on that edge and out_valid→0.
  - Any input fire in that same cycle is dropped, since in_ready is already 0 once in ST_DONE on the next cycle.
- start while in ST_RUN: restart. Counters clear, out_valid→0, the pending result is discarded unscored, and the state remains ST_RUN.
- Reset mid-run: immediate return to reset values; no partial score is retained.

Optional Feature:
- ENC_ONEHOT_CHECK_EN defined:
  - onehot_err is registered alongside a on input fire. It is 1 when popcount(b)>1.
  - A vector with onehot_err=1 is scored as a pass regardless of test_a, because priority is ambiguous for quiz purposes.
- ENC_ONEHOT_CHECK_EN undefined:
  - onehot_err tied to 0.
  - Scoring uses pure priority encoding for all inputs.

Test Plan:
- Reset values: hold sys_rst_n=0 3 cycles, then release → all outputs 0; in_ready=0 until start.
- Basic encode: start; b=4'b0100 with in_valid, out_ready=1, test_a=2 → next cycle a=2, out_valid=1; at that output fire pass_cnt=1, check_res=1.
- Priority and empty input:
  - b=4'b1011 → a=3.
  - b=4'b0000 → a=0, a_none=1.
  - test_a=1 on the b=4'b1011 result → fail_cnt=1, check_res=0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → a is stable and in_ready=0; release → one score only.
- Completion with N_VEC=16: 16 handshakes with all-correct answers → done=1, pass_cnt=16, fail_cnt=0; further in_valid is ignored; start → counters return to 0.
- Optional feature with ENC_ONEHOT_CHECK_EN: b=4'b0011, test_a=0 → onehot_err=1, pass_cnt increments; without the macro → fail_cnt increments.
